// File: rtl/ga25_gfx_line_cache.sv
// Direct-mapped read cache for GA25 pixel fetch. Serves 32-bit word reads from 64-bit lines
// and fills misses with one 64-bit request on arbiter port C.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for rd_req; latches the request address
// S_LOOKUP | tag/valid compare on the latched address; hit returns data, miss issues mem_req
// S_FILL   | waiting for mem_rdy; writes the line, returns the selected word
module ga25_gfx_line_cache #(
   parameter int IDX_BITS = 4,
   parameter int ADDR_W   = 22
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_req,
   output logic [31:0]       rd_data,
   output logic              rd_rdy,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic [63:0]       mem_data,
   input  logic              mem_rdy
);

   localparam int LINES = 1 << IDX_BITS;
   localparam int TAG_W = ADDR_W - 3 - IDX_BITS;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_FILL   = 2'd2;

   logic [1:0]          state;
   logic [ADDR_W-1:2]   req_addr;
   logic [LINES-1:0]    valid;
   logic                flush_seen;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [63:0]         data_mem [LINES];

   logic [IDX_BITS-1:0] req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                word_sel;
   logic                hit;
   logic [63:0]         hit_line;
   logic [31:0]         hit_word;
   logic [31:0]         fill_word;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^rd_addr[1:0];

   assign req_idx   = req_addr[2+IDX_BITS:3];
   assign req_tag   = req_addr[ADDR_W-1:3+IDX_BITS];
   assign word_sel  = req_addr[2];
   assign hit_line  = data_mem[req_idx];
   assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
   assign fill_word = word_sel ? mem_data[63:32] : mem_data[31:0];
   // A flush landing on the lookup cycle wins over the stale valid bit.
   assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         req_addr   <= '0;
         valid      <= '0;
         flush_seen <= 1'b0;
         rd_rdy     <= 1'b0;
         rd_data    <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         rd_rdy  <= 1'b0;
         mem_req <= 1'b0;
         if (flush) valid <= '0;
         case (state)
            S_IDLE: begin
               // The rd_rdy cycle is still part of the previous transaction.
               if (rd_req && !rd_rdy) begin
                  req_addr <= rd_addr[ADDR_W-1:2];
                  state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  rd_data <= hit_word;
                  rd_rdy  <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  mem_addr   <= {req_addr[ADDR_W-1:3], 3'b000};
                  mem_req    <= 1'b1;
                  flush_seen <= 1'b0;
                  state      <= S_FILL;
               end
            end
            S_FILL: begin
               if (flush) flush_seen <= 1'b1;
               if (mem_rdy) begin
                  rd_data <= fill_word;
                  rd_rdy  <= 1'b1;
                  state   <= S_IDLE;
                  if (!(flush || flush_seen)) valid[req_idx] <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_FILL && mem_rdy) begin
         data_mem[req_idx] <= mem_data;
         tag_mem[req_idx]  <= req_tag;
      end
   end

endmodule

// File: doc/ga25_gfx_line_cache.md
Name: ga25_gfx_line_cache

Overview:
- Direct-mapped read cache between the GA25 tile/sprite pixel fetch logic and the 64-bit port (port C) of the graphics SDRAM arbiter.
- The requester makes 32-bit word reads; the cache serves them from 64-bit lines and fills misses with one 64-bit arbiter request.
- Purpose: cut arbiter traffic for adjacent-word fetches, where two consecutive words share one 8-byte line.

Parameters:
- IDX_BITS, 4, log2 of the line count (default 16 lines of 64 bits).
- ADDR_W, 22, byte-address width; matches the arbiter port address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  ADDR_W  byte address of the 32-bit word; bits [1:0] ignored.
- rd_req  in  1  one-cycle request pulse.
- rd_data  out  32  read data; valid when rd_rdy=1.
- rd_rdy  out  1  one-cycle completion pulse.
- flush  in  1  one-cycle pulse; invalidates all lines.
- mem_addr  out  ADDR_W  line address to the arbiter port C; bits [2:0] always 0.
- mem_req  out  1  one-cycle request pulse to the arbiter.
- mem_data  in  64  line data from the arbiter; valid when mem_rdy=1.
- mem_rdy  in  1  one-cycle completion pulse from the arbiter.

Behaviour:
- Address split:
  - word select = rd_addr[2]
  - index = rd_addr[2+IDX_BITS:3]
  - tag = rd_addr[ADDR_W-1:3+IDX_BITS]
- Storage: per line, a valid bit, a tag, and 64 bits of data. Data and tags may be inferred RAM with one-cycle registered read.
- Word select on output: rd_addr[2]=0 returns line[31:0]; rd_addr[2]=1 returns line[63:32].
- Reset: state=IDLE; all valid bits cleared; rd_rdy=0, mem_req=0, rd_data=0, mem_addr=0. Reset asserted mid-fill abandons the fill.
- States:
  - IDLE: on rd_req, latch the address and go to LOOKUP. rd_req is ignored in every other state; the requester must not issue a new request before rd_rdy.
  - LOOKUP (1 cycle, RAM read): on hit (valid and tag equal), drive rd_data, pulse rd_rdy, go to IDLE. On miss, set mem_addr={line addr,3'b000}, pulse mem_req for 1 cycle, go to FILL.
  - FILL: wait for mem_rdy. In that cycle, write mem_data and the tag to the line and set valid unless a flush arrived during the fill. Select the word from mem_data directly, drive rd_data, pulse rd_rdy in the next cycle, go to IDLE.
- Latency, rd_req at cycle T:
  - hit: rd_rdy at T+2.
  - miss: mem_req at T+2; rd_rdy one cycle after mem_rdy.
- Back-to-back: a new rd_req in the same cycle as rd_rdy is ignored. A new rd_req the cycle after rd_rdy is accepted, so a hit stream runs at one word per 3 cycles.
- flush:
  - Clears all valid bits in one cycle, in any state.
  - flush and rd_req together in IDLE: the flush applies first, so the lookup misses.
  - flush during FILL: the outstanding fill still returns its data to the requester but leaves the line invalid.
- mem_rdy outside FILL, e.g. a stray response after reset: ignored, no state change.
- mem_req is never asserted while a fill is outstanding; at most one outstanding arbiter request.
- rd_data holds its last value between rd_rdy pulses.
- Conflict replacement: a miss overwrites the indexed line unconditionally. No write path; the SDRAM graphics region is read-only at runtime.

Test Plan:
- Cold miss: after reset, read 0x000104 with mem_data=0x11223344_55667788 and mem_rdy 5 cycles after mem_req -> mem_addr=0x000100, one mem_req pulse, rd_data=0x11223344, rd_rdy one cycle after mem_rdy.
- Hit on the same line: then read 0x000100 -> no mem_req; rd_data=0x55667788 with rd_rdy exactly 2 cycles after rd_req.
- Conflict: read 0x000900 (same index 0, different tag) -> miss and fill. A following read of 0x000100 misses again and issues mem_req with mem_addr=0x000100.
- Flush: fill line 0x000100, pulse flush, read 0x000100 -> miss and new mem_req. Flush during FILL -> rd_data correct, but an immediate re-read misses.
- Reset mid-fill: assert reset_n=0 during FILL, release, then pulse mem_rdy -> no rd_rdy, state IDLE. The next read of the same address issues mem_req.
- Request discipline: rd_req pulsed during FILL and in the rd_rdy cycle -> ignored; exactly one rd_rdy per accepted request; mem_req count equals the miss count over a 1000-read random-address run checked against a reference model.
